fsm3_seq_detector: RTL and testbench
====================================

// Module: fsm3_seq_detector
// PURPOSE
//   Serial bit-pattern detector (Moore FSM) for a 1-bit stream.
//   Samples seq on every rising clk edge and pulses dout for one cycle when the
//   last PAT_LEN sampled bits equal PATTERN (MSB = first bit received).
//   Leaf block feeding control logic that needs a registered, glitch-free match flag.
// PARAMETERS
//   PAT_LEN  4        pattern length in bits; legal range 2..8 (elaboration error otherwise)
//   PATTERN  4'b1011  pattern to detect; bit [PAT_LEN-1] is received first
//   OVERLAP  1        1: matches may share bits; 0: search restarts empty after a match
// PORTS
//   clk   in  1  clock; all state changes on the rising edge
//   rst   in  1  reset; asynchronous, active-low
//   seq   in  1  serial data bit, sampled on rising clk
//   dout  out 1  match pulse, registered; high for exactly one cycle per match
// BEHAVIOUR
//   - Reset: rst=0 forces state S0 and dout=0 immediately, regardless of clk.
//     Reset release is synchronised by the rising clk edge; first sample is the
//     first rising edge with rst=1.
//   - States S0..S{PAT_LEN}: Sk = the first k pattern bits are matched as the
//     most recent input suffix. S{PAT_LEN} is the match state.
//   - Next state from Sk on bit b = length of the longest pattern prefix that is
//     a suffix of (matched prefix, b). Standard KMP failure rule. Compute it at
//     elaboration or in a function; no runtime tables.
//   - From S{PAT_LEN}: OVERLAP=1 applies the same rule. OVERLAP=0 treats it as
//     S0, so the next state is S1 if b==PATTERN[PAT_LEN-1], else S0.
//   - Default pattern 1011, OVERLAP=1:
//       S0: 0->S0, 1->S1
//       S1: 0->S2, 1->S1
//       S2: 0->S0, 1->S3
//       S3: 0->S2, 1->S4
//       S4: 0->S2, 1->S1
//   - dout is a flop loaded with (next_state==S{PAT_LEN}). It rises at the same
//     clk edge that samples the final pattern bit (latency 0 cycles after that
//     edge) and stays high one clock cycle.
//     Back-to-back matches, possible only when the pattern allows it (for example
//     an all-ones pattern with OVERLAP=1), keep dout high on consecutive cycles.
//   - No combinational path from seq to dout.
//   - Reset mid-sequence discards all partial matches; bits sampled before the
//     reset never contribute to a later match.
//   - State register width = $clog2(PAT_LEN+1); binary encoding.
//     Unreachable codes return to S0 on the next edge.
// STRUCTURE
//   - Package fsm3_pkg:
//       default PATTERN/PAT_LEN constants
//       state-width function
//       pure function next_state(k, b, PATTERN, PAT_LEN, OVERLAP)
//   - No sub-module. One always block handles the state + dout registers with
//     async reset; one combinational block computes next_state.
// TESTING
//   - Hold rst=0 for 2 cycles with seq toggling -> dout=0, state S0.
//     Then deassert rst between clk edges -> no change until the next rising edge.
//   - Defaults, rst=1, seq stream 1,0,1,1 -> dout=1 only in the cycle after the
//     4th edge, then 0.
//   - Defaults, stream 1,0,1,1,0,1,1 -> dout pulses after bit 4 and bit 7
//     (overlap reuses "1"+"0" tail... verify state S4->S2->S3->S4).
//   - OVERLAP=0, PATTERN=4'b1111, stream of 8 ones -> pulses after bits 4 and 8
//     only. With OVERLAP=1 -> pulses after bits 4,5,6,7,8.
//   - Defaults, stream 1,0,1, then pulse rst=0 asynchronously, then 1 ->
//     no pulse. Then 0,1,1 completes 1011 -> pulse.
//   - Streams 0000_0000 and 1111_1111 on defaults -> dout stays 0 throughout.

Source files
------------

// File: rtl/fsm3_seq_detector_pkg.sv
`default_nettype none
// ============================================================================
// Package : fsm3_pkg
// Default pattern constants plus elaboration-time helpers for the detector.
// Rev     : 1.0
// ============================================================================
package fsm3_pkg;

  localparam int         c_DEF_PAT_LEN = 4;
  localparam logic [3:0] c_DEF_PATTERN = 4'b1011;
  localparam int         c_MAX_PAT_LEN = 8;

  function automatic int state_width(input int pat_len);
    return $clog2(pat_len + 1);
  endfunction

  // Longest pattern prefix that is a suffix of (first k pattern bits, b).
  // Strings are held MSB-first, so a prefix of length L is pattern >> (pat_len-L).
  function automatic int next_state(input int k, input logic b, input logic [7:0] pattern,
                                    input int pat_len, input bit overlap);
    logic [15:0] pat;
    logic [15:0] hist;
    logic [15:0] mask;
    logic [15:0] pre;
    int          kk;
    int          best;
    pat  = 16'(pattern) & ((16'd1 << pat_len) - 16'd1);
    kk   = (k >= pat_len && !overlap) ? 0 : k;
    hist = ((pat >> (pat_len - kk)) << 1) | 16'(b);
    best = 0;
    for (int l = 1; l <= c_MAX_PAT_LEN + 1; l++) begin
      if (l <= pat_len && l <= kk + 1) begin
        mask = (16'd1 << l) - 16'd1;
        pre  = (pat >> (pat_len - l)) & mask;
        if ((hist & mask) == pre) begin
          best = l;
        end
      end
    end
    return best;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fsm3_seq_detector_if.sv
`default_nettype none
// ============================================================================
// Interface : fsm3_seq_detector_if
// Serial bit stream in, registered match pulse out.
// Rev       : 1.0
// ============================================================================
interface fsm3_seq_detector_if;

  logic seq;
  logic dout;

  modport master (output seq, input dout);
  modport slave  (input seq, output dout);

endinterface
`default_nettype wire

// File: rtl/fsm3_seq_detector.sv
`default_nettype none
// ============================================================================
// Module : fsm3_seq_detector
// Moore detector of a PAT_LEN-bit serial pattern with registered match pulse.
// Rev    : 1.0
// ============================================================================
module fsm3_seq_detector
  import fsm3_pkg::*;
#(
  parameter int               PAT_LEN = c_DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = c_DEF_PATTERN,
  parameter bit               OVERLAP = 1'b1
) (
  input  wire logic        clk,
  input  wire logic        rst,
  fsm3_seq_detector_if.slave bus
);

  localparam int         c_SW       = state_width(PAT_LEN);
  localparam logic [7:0] c_PATTERN8 = 8'(PATTERN);

  if (PAT_LEN < 2 || PAT_LEN > c_MAX_PAT_LEN) begin : g_bad_pat_len
    $error("fsm3_seq_detector: PAT_LEN must be in 2..8");
  end

  // Intermediate states S1..S{PAT_LEN-1} are plain binary codes between these two.
  typedef enum logic [c_SW-1:0] {
    S0      = '0,
    S_MATCH = c_SW'(PAT_LEN)
  } state_e;

  state_e r_state;
  state_e w_next_state;
  logic   r_dout;

  // Each reachable code maps to a constant transition; any other code falls to S0.
  always_comb begin
    w_next_state = S0;
    for (int k = 0; k <= PAT_LEN; k++) begin
      if (r_state == state_e'(c_SW'(k))) begin
        w_next_state = state_e'(c_SW'(next_state(k, bus.seq, c_PATTERN8, PAT_LEN, OVERLAP)));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S0;
      r_dout  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_dout  <= (w_next_state == S_MATCH);
    end
  end

  assign bus.dout = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_fsm3_seq_detector.sv
`default_nettype none
// ============================================================================
// Module : tb_fsm3_seq_detector
// Directed bench: default 1011 detector plus 1111 detectors with and without overlap.
// Rev    : 1.0
// ============================================================================
module tb_fsm3_seq_detector;

  typedef struct {
    bit rst_before;
    bit seq;
    bit e_def;
    bit e_o0;
    bit e_o1;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  vec_t vecs[$];

  fsm3_seq_detector_if if_def ();
  fsm3_seq_detector_if if_o0 ();
  fsm3_seq_detector_if if_o1 ();

  fsm3_seq_detector u_def (
    .clk (clk),
    .rst (rst),
    .bus (if_def.slave)
  );

  fsm3_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1111), .OVERLAP(1'b0)) u_o0 (
    .clk (clk),
    .rst (rst),
    .bus (if_o0.slave)
  );

  fsm3_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1111), .OVERLAP(1'b1)) u_o1 (
    .clk (clk),
    .rst (rst),
    .bus (if_o1.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic b);
    if_def.seq = b;
    if_o0.seq  = b;
    if_o1.seq  = b;
  endtask

  task automatic step(input logic b);
    @(negedge clk);
    drive(b);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic add(input bit r, input bit s, input bit d, input bit o0, input bit o1);
    vec_t v;
    v.rst_before = r;
    v.seq        = s;
    v.e_def      = d;
    v.e_o0       = o0;
    v.e_o1       = o1;
    vecs.push_back(v);
  endtask

  initial begin
    // Overlapping 1011 stream: pulses on bits 4 and 7
    add(1, 1, 0, 0, 0); add(0, 0, 0, 0, 0); add(0, 1, 0, 0, 0); add(0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0); add(0, 1, 0, 0, 0); add(0, 1, 1, 0, 0); add(0, 0, 0, 0, 0);
    // Eight ones: 1111 without overlap hits at 4,8; with overlap at 4..8
    add(1, 1, 0, 0, 0); add(0, 1, 0, 0, 0); add(0, 1, 0, 0, 0); add(0, 1, 0, 1, 1);
    add(0, 1, 0, 0, 1); add(0, 1, 0, 0, 1); add(0, 1, 0, 0, 1); add(0, 1, 0, 1, 1);
    // Eight zeros: nothing matches
    add(1, 0, 0, 0, 0); add(0, 0, 0, 0, 0); add(0, 0, 0, 0, 0); add(0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0); add(0, 0, 0, 0, 0); add(0, 0, 0, 0, 0); add(0, 0, 0, 0, 0);
    // 1101011: failure transitions S1->S1, S3->S2 before the final match
    add(1, 1, 0, 0, 0); add(0, 1, 0, 0, 0); add(0, 0, 0, 0, 0); add(0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0); add(0, 1, 0, 0, 0); add(0, 1, 1, 0, 0);

    drive(1'b0);
    rst = 1'b0;

    // Reset held while seq toggles
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive((i % 2 == 0) ? 1'b1 : 1'b0);
      @(posedge clk);
      #1;
      check("rst_hold_dout_def", int'(if_def.dout), 0);
      check("rst_hold_dout_o1", int'(if_o1.dout), 0);
      check("rst_hold_state", int'(u_def.r_state), 0);
    end

    // Release between edges: nothing moves until the next rising edge
    @(negedge clk);
    drive(1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("release_no_edge_state", int'(u_def.r_state), 0);
    check("release_no_edge_dout", int'(if_def.dout), 0);
    @(posedge clk);
    #1;
    check("first_sample_state", int'(u_def.r_state), 1);
    check("first_sample_dout", int'(if_def.dout), 0);
    step(1'b0); check("s1011_b2", int'(if_def.dout), 0);
    step(1'b1); check("s1011_b3", int'(if_def.dout), 0);
    step(1'b1); check("s1011_b4", int'(if_def.dout), 1);
    check("s1011_match_state", int'(u_def.r_state), 4);
    step(1'b0); check("s1011_after", int'(if_def.dout), 0);
    check("s1011_after_state", int'(u_def.r_state), 2);

    // Async reset while dout is high clears it without a clock edge
    step(1'b1); check("pre_async_b3", int'(if_def.dout), 0);
    step(1'b1); check("pre_async_b4", int'(if_def.dout), 1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_dout", int'(if_def.dout), 0);
    check("async_rst_state", int'(u_def.r_state), 0);
    @(negedge clk);
    rst = 1'b1;

    // 1,0,1 then async reset pulse: partial match discarded
    step(1'b1); check("mid_b1", int'(if_def.dout), 0);
    step(1'b0); check("mid_b2", int'(if_def.dout), 0);
    step(1'b1); check("mid_b3", int'(if_def.dout), 0);
    #1;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    check("mid_rst_state", int'(u_def.r_state), 0);
    step(1'b1); check("mid_after_rst_1", int'(if_def.dout), 0);
    step(1'b0); check("mid_after_rst_0", int'(if_def.dout), 0);
    step(1'b1); check("mid_after_rst_1b", int'(if_def.dout), 0);
    step(1'b1); check("mid_after_rst_match", int'(if_def.dout), 1);

    // Table-driven vectors
    foreach (vecs[i]) begin
      if (vecs[i].rst_before) begin
        pulse_reset();
      end
      step(vecs[i].seq);
      check($sformatf("vec%0d_def", i), int'(if_def.dout), int'(vecs[i].e_def));
      check($sformatf("vec%0d_o0", i), int'(if_o0.dout), int'(vecs[i].e_o0));
      check($sformatf("vec%0d_o1", i), int'(if_o1.dout), int'(vecs[i].e_o1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
